// File: rtl/fsmc_slot_ctrl.sv
// -----------------------------------------------------------------------------
// fsmc_slot_ctrl
//
// Turns FSMC bus transactions, as decoded by the FSMC interface into a slot
// select plus a one-cycle read or write strobe, into a registered req/ack
// handshake toward one of SLOTS peripheral slots. Read data returned by the
// slot is captured and held so the interface can drive it onto AD during NOE.
// Timeout, overrun and decode errors are reported through sticky flags.
//
// Ports
//   clk         system clock, all logic on the rising edge
//   reset_n     asynchronous active-low reset
//   cs          one-hot slot select, sampled only on a strobe
//   wr_strobe   1-cycle pulse: write wr_data to slot cs
//   rd_strobe   1-cycle pulse: read from slot cs
//   wr_data     write data, sampled only on wr_strobe
//   rd_data     captured read data (all-ones after a failed read)
//   busy        a transaction is in flight
//   slot_req    one-hot request toward the selected slot
//   slot_we     1 = write, 0 = read; valid while slot_req != 0
//   slot_wdata  latched write data; valid while slot_req != 0
//   slot_ack    per-slot completion, single-cycle pulse or level
//   slot_rdata  per-slot read data, slot i at [i*DATA_W +: DATA_W]
//   err         sticky flags: [0] timeout, [1] overrun, [2] bad cs
//   err_clr     clears err; an error raised in the same cycle still sets
// -----------------------------------------------------------------------------
module fsmc_slot_ctrl #(
  parameter int DATA_W  = 16,
  parameter int SLOTS   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [SLOTS-1:0]          cs,
  input  logic                      wr_strobe,
  input  logic                      rd_strobe,
  input  logic [DATA_W-1:0]         wr_data,
  output logic [DATA_W-1:0]         rd_data,
  output logic                      busy,
  output logic [SLOTS-1:0]          slot_req,
  output logic                      slot_we,
  output logic [DATA_W-1:0]         slot_wdata,
  input  logic [SLOTS-1:0]          slot_ack,
  input  logic [SLOTS*DATA_W-1:0]   slot_rdata,
  output logic [2:0]                err,
  input  logic                      err_clr
);

  // The timer counts 0 .. TIMEOUT-1 while a request is outstanding, so it
  // never has to hold TIMEOUT itself.
  localparam int                 TIMER_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

  localparam int ERR_TIMEOUT = 0;
  localparam int ERR_OVERRUN = 1;
  localparam int ERR_BAD_CS  = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_WR = 2'd1,
    WAIT_RD = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [TIMER_W-1:0] timer_reg,      timer_next;
  logic [SLOTS-1:0]   slot_req_reg,   slot_req_next;
  logic               slot_we_reg,    slot_we_next;
  logic [DATA_W-1:0]  slot_wdata_reg, slot_wdata_next;
  logic [DATA_W-1:0]  rd_data_reg,    rd_data_next;
  logic               busy_reg,       busy_next;
  logic [2:0]         err_reg,        err_next;
  logic [2:0]         err_new;

  // ---------------------------------------------------------------------------
  // Decode helpers
  // ---------------------------------------------------------------------------
  logic cs_onehot;
  logic strobe_any;
  logic in_wait;
  logic ack_sel;
  logic timer_done;

  // Zero and multi-hot selects are both rejected as decode errors.
  assign cs_onehot  = (cs != '0) && ((cs & (cs - SLOTS'(1))) == '0);
  assign strobe_any = wr_strobe | rd_strobe;
  assign in_wait    = (state_reg == WAIT_WR) || (state_reg == WAIT_RD);

  // slot_req_reg is one-hot while waiting, so masking the acks with it keeps
  // only the selected slot's ack and ignores all others.
  assign ack_sel    = |(slot_ack & slot_req_reg);
  assign timer_done = (timer_reg == TIMER_LAST);

  // Read-data mux driven by the one-hot request: every slot's word is gated
  // by its request bit and the gated words are OR-ed together.
  logic [DATA_W-1:0] rdata_masked [SLOTS];
  logic [DATA_W-1:0] rdata_sel;

  genvar gi;
  generate
    for (gi = 0; gi < SLOTS; gi++) begin : g_rdata_mask
      assign rdata_masked[gi] = slot_req_reg[gi] ? slot_rdata[gi*DATA_W +: DATA_W]
                                                 : '0;
    end
  endgenerate

  always_comb begin
    rdata_sel = '0;
    for (int i = 0; i < SLOTS; i++) begin
      rdata_sel = rdata_sel | rdata_masked[i];
    end
  end

  // ---------------------------------------------------------------------------
  // State register (all outputs are registered alongside the state)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      timer_reg      <= '0;
      slot_req_reg   <= '0;
      slot_we_reg    <= 1'b0;
      slot_wdata_reg <= '0;
      rd_data_reg    <= '0;
      busy_reg       <= 1'b0;
      err_reg        <= '0;
    end else begin
      state_reg      <= state_next;
      timer_reg      <= timer_next;
      slot_req_reg   <= slot_req_next;
      slot_we_reg    <= slot_we_next;
      slot_wdata_reg <= slot_wdata_next;
      rd_data_reg    <= rd_data_next;
      busy_reg       <= busy_next;
      err_reg        <= err_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE: begin
        // A write takes priority over a simultaneous read.
        if (wr_strobe && cs_onehot) begin
          state_next = WAIT_WR;
        end else if (rd_strobe && !wr_strobe && cs_onehot) begin
          state_next = WAIT_RD;
        end
      end
      WAIT_WR,
      WAIT_RD: begin
        // An ack on the last allowed cycle still ends the wait as a success.
        if (ack_sel || timer_done) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output / datapath logic (next values of the registered outputs)
  // ---------------------------------------------------------------------------
  always_comb begin
    timer_next      = timer_reg;
    slot_req_next   = slot_req_reg;
    slot_we_next    = slot_we_reg;
    slot_wdata_next = slot_wdata_reg;
    rd_data_next    = rd_data_reg;
    err_new         = '0;

    unique case (state_reg)
      IDLE: begin
        timer_next = '0;
        if (wr_strobe) begin
          if (cs_onehot) begin
            slot_req_next   = cs;
            slot_we_next    = 1'b1;
            slot_wdata_next = wr_data;
          end else begin
            err_new[ERR_BAD_CS] = 1'b1;
          end
          // The read half of a simultaneous strobe pair is dropped.
          if (rd_strobe) begin
            err_new[ERR_OVERRUN] = 1'b1;
          end
        end else if (rd_strobe) begin
          if (cs_onehot) begin
            slot_req_next = cs;
            slot_we_next  = 1'b0;
          end else begin
            err_new[ERR_BAD_CS] = 1'b1;
            rd_data_next        = '1;
          end
        end
      end

      WAIT_WR,
      WAIT_RD: begin
        // The in-flight transaction is not disturbed by a new strobe.
        if (strobe_any) begin
          err_new[ERR_OVERRUN] = 1'b1;
        end
        if (ack_sel) begin
          slot_req_next = '0;
          slot_we_next  = 1'b0;
          if (state_reg == WAIT_RD) begin
            rd_data_next = rdata_sel;
          end
        end else if (timer_done) begin
          slot_req_next         = '0;
          slot_we_next          = 1'b0;
          err_new[ERR_TIMEOUT]  = 1'b1;
          if (state_reg == WAIT_RD) begin
            rd_data_next = '1;
          end
        end else begin
          timer_next = timer_reg + TIMER_W'(1);
        end
      end

      default: begin
        slot_req_next = '0;
        slot_we_next  = 1'b0;
      end
    endcase

    // Sticky flags; a fresh error beats a clear in the same cycle.
    err_next  = (err_clr ? 3'b000 : err_reg) | err_new;
    busy_next = (state_next != IDLE);
  end

  // ---------------------------------------------------------------------------
  // Port assignments
  // ---------------------------------------------------------------------------
  assign rd_data    = rd_data_reg;
  assign busy       = busy_reg;
  assign slot_req   = slot_req_reg;
  assign slot_we    = slot_we_reg;
  assign slot_wdata = slot_wdata_reg;
  assign err        = err_reg;

  // in_wait is kept for readability of the decode section only.
  logic unused_ok;
  assign unused_ok = in_wait;

endmodule

// File: tb/tb_fsmc_slot_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fsmc_slot_ctrl
//
// Table-driven bench for fsmc_slot_ctrl. Each table record describes one
// transaction (strobes, select, data, ack timing) plus the expected handshake
// length, rd_data and err. The driver pushes the expectation into a queue on
// the strobe; a negedge monitor checks every request cycle against the head
// of the queue and pops it when busy falls. Hand-written sequences cover the
// simultaneous/overrun strobes, bad selects, err_clr priority and reset
// in the middle of a transaction.
// -----------------------------------------------------------------------------
module tb_fsmc_slot_ctrl;

  localparam int DW = 16;
  localparam int NS = 4;
  localparam int TO = 15;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [NS-1:0]     cs;
  logic              wr_strobe;
  logic              rd_strobe;
  logic [DW-1:0]     wr_data;
  logic [DW-1:0]     rd_data;
  logic              busy;
  logic [NS-1:0]     slot_req;
  logic              slot_we;
  logic [DW-1:0]     slot_wdata;
  logic [NS-1:0]     slot_ack;
  logic [NS*DW-1:0]  slot_rdata;
  logic [2:0]        err;
  logic              err_clr;

  always #5 clk = ~clk;

  fsmc_slot_ctrl #(
    .DATA_W  (DW),
    .SLOTS   (NS),
    .TIMEOUT (TO)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cs         (cs),
    .wr_strobe  (wr_strobe),
    .rd_strobe  (rd_strobe),
    .wr_data    (wr_data),
    .rd_data    (rd_data),
    .busy       (busy),
    .slot_req   (slot_req),
    .slot_we    (slot_we),
    .slot_wdata (slot_wdata),
    .slot_ack   (slot_ack),
    .slot_rdata (slot_rdata),
    .err        (err),
    .err_clr    (err_clr)
  );

  typedef struct {
    bit            wr;
    bit            rd;
    logic [NS-1:0] cs;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    int            ack_cyc;     // request cycle (1-based) carrying the ack; 0 = none
    logic [NS-1:0] extra_ack;   // acks driven on non-selected slots while waiting
    int            mid_cyc;     // request cycle with an extra rd_strobe; 0 = none
    bit            no_clr;      // skip the err_clr pulse before the strobe
    int            exp_cycles;
    logic [DW-1:0] exp_rd;
    logic [2:0]    exp_err;
  } vec_t;

  typedef struct {
    logic [NS-1:0] req;
    logic          we;
    logic [DW-1:0] wdata;
    int            cycles;
    logic [DW-1:0] rd;
    logic [2:0]    err;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mkv(bit wr, bit rd, logic [NS-1:0] c, logic [DW-1:0] wd,
                               logic [DW-1:0] rdv, int ack, logic [NS-1:0] extra,
                               int mid, bit no_clr, int ecyc, logic [DW-1:0] erd,
                               logic [2:0] eerr);
    vec_t v;
    v.wr = wr; v.rd = rd; v.cs = c; v.wdata = wd; v.rdata = rdv;
    v.ack_cyc = ack; v.extra_ack = extra; v.mid_cyc = mid; v.no_clr = no_clr;
    v.exp_cycles = ecyc; v.exp_rd = erd; v.exp_err = eerr;
    return v;
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------------
  bit   mon_en    = 1'b0;
  int   req_cnt   = 0;
  logic prev_busy = 1'b0;
  exp_t mon_e;

  always @(negedge clk) begin
    if (!mon_en) begin
      req_cnt   = 0;
      prev_busy = 1'b0;
    end else begin
      if (slot_req != '0) begin
        req_cnt++;
        if (sb.size() == 0) begin
          chk("orphan_req", 32'(slot_req), 32'd0);
        end else begin
          chk("slot_req", 32'(slot_req), 32'(sb[0].req));
          chk("slot_we",  32'(slot_we),  32'(sb[0].we));
          if (sb[0].we) chk("slot_wdata", 32'(slot_wdata), 32'(sb[0].wdata));
        end
      end
      if (prev_busy && !busy) begin
        if (sb.size() == 0) begin
          chk("busy_fall_unexpected", 32'(busy), 32'd1);
        end else begin
          mon_e = sb.pop_front();
          chk("req_cycles", 32'(req_cnt), 32'(mon_e.cycles));
          chk("rd_data",    32'(rd_data), 32'(mon_e.rd));
          chk("err",        32'(err),     32'(mon_e.err));
          chk("req_drop",   32'(slot_req), 32'd0);
          $display("txn done: req=%b cycles=%0d rd_data=%h err=%b", mon_e.req,
                   req_cnt, rd_data, err);
        end
        req_cnt = 0;
      end
      prev_busy = busy;
    end
  end

  // ---------------------------------------------------------------------------
  // Driver
  // ---------------------------------------------------------------------------
  task automatic run_vec(input vec_t v);
    exp_t e;
    bit   done;
    @(negedge clk);
    if (!v.no_clr) begin
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
    end
    for (int i = 0; i < NS; i++) begin
      slot_rdata[i*DW +: DW] = v.cs[i] ? v.rdata : ~v.rdata;
    end
    cs        = v.cs;
    wr_data   = v.wdata;
    wr_strobe = v.wr;
    rd_strobe = v.rd;
    e.req = v.cs; e.we = v.wr; e.wdata = v.wdata;
    e.cycles = v.exp_cycles; e.rd = v.exp_rd; e.err = v.exp_err;
    sb.push_back(e);
    @(negedge clk);
    wr_strobe = 1'b0;
    rd_strobe = 1'b0;
    // Select and data change after the strobe must not leak into the request.
    cs        = ~v.cs;
    wr_data   = ~v.wdata;
    done      = 1'b0;
    for (int c = 1; c <= TO + 4; c++) begin
      slot_ack = (v.extra_ack & ~v.cs) | ((c == v.ack_cyc) ? v.cs : '0);
      if (c == v.mid_cyc) rd_strobe = 1'b1;
      @(negedge clk);
      slot_ack  = '0;
      rd_strobe = 1'b0;
      if (!busy) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) chk("txn_bound_busy", 32'(busy), 32'd0);
  endtask

  vec_t vecs[8];

  initial begin
    $display("watchdog armed");
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, busy=%0b", busy);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n    = 1'b0;
    cs         = '0;
    wr_strobe  = 1'b0;
    rd_strobe  = 1'b0;
    wr_data    = '0;
    slot_ack   = '0;
    slot_rdata = '0;
    err_clr    = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_rd_data",    32'(rd_data),    32'd0);
    chk("rst_busy",       32'(busy),       32'd0);
    chk("rst_slot_req",   32'(slot_req),   32'd0);
    chk("rst_slot_we",    32'(slot_we),    32'd0);
    chk("rst_slot_wdata", 32'(slot_wdata), 32'd0);
    chk("rst_err",        32'(err),        32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    mon_en  = 1'b1;

    //            wr rd cs       wdata     rdata    ack extra    mid nclr cyc rd        err
    vecs[0] = mkv(1, 0, 4'b0100, 16'h0F0F, 16'h0000, 3, 4'b0000, 0, 0,  3, 16'h0000, 3'b000);
    vecs[1] = mkv(0, 1, 4'b0010, 16'h0000, 16'h2321, 1, 4'b0000, 0, 0,  1, 16'h2321, 3'b000);
    vecs[2] = mkv(1, 0, 4'b1000, 16'hA5A5, 16'h0000, 2, 4'b0000, 0, 0,  2, 16'h2321, 3'b000);
    vecs[3] = mkv(0, 1, 4'b0001, 16'h0000, 16'h1357, 0, 4'b0000, 0, 0, TO, 16'hFFFF, 3'b001);
    vecs[4] = mkv(0, 1, 4'b1000, 16'h0000, 16'hBEEF, TO, 4'b0000, 0, 0, TO, 16'hBEEF, 3'b000);
    vecs[5] = mkv(1, 0, 4'b0001, 16'h1234, 16'h0000, TO+1, 4'b0000, 0, 0, TO, 16'hBEEF, 3'b001);
    vecs[6] = mkv(0, 1, 4'b0100, 16'h0000, 16'h5A5A, 2, 4'b1011, 0, 0,  2, 16'h5A5A, 3'b000);
    vecs[7] = mkv(0, 1, 4'b0001, 16'h0000, 16'h0001, 5, 4'b1110, 0, 0,  5, 16'h0001, 3'b000);

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i]);
    end

    // Simultaneous wr+rd strobe, then a read strobe while the write waits.
    run_vec(mkv(1, 1, 4'b0010, 16'hC0DE, 16'h0000, 3, 4'b0000, 1, 0, 3, 16'h0001, 3'b010));
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_clr", 32'(err), 32'd0);
    $display("err_clr: err=%b", err);

    // Bad (multi-hot) cs read together with err_clr: new error wins.
    err_clr   = 1'b1;
    cs        = 4'b0011;
    rd_strobe = 1'b1;
    slot_ack  = 4'b0001;
    @(negedge clk);
    err_clr   = 1'b0;
    rd_strobe = 1'b0;
    chk("badcs_multi_req",  32'(slot_req), 32'd0);
    chk("badcs_multi_busy", 32'(busy),     32'd0);
    chk("badcs_multi_err",  32'(err),      32'b100);
    chk("badcs_multi_rd",   32'(rd_data),  32'hFFFF);
    $display("bad cs 0011: req=%b err=%b rd_data=%h", slot_req, err, rd_data);

    // Zero cs read, with a stray ack still present.
    cs        = 4'b0000;
    rd_strobe = 1'b1;
    @(negedge clk);
    rd_strobe = 1'b0;
    @(negedge clk);
    slot_ack  = '0;
    chk("badcs_zero_req",  32'(slot_req), 32'd0);
    chk("badcs_zero_busy", 32'(busy),     32'd0);
    chk("badcs_zero_err",  32'(err),      32'b100);
    chk("badcs_zero_rd",   32'(rd_data),  32'hFFFF);
    $display("bad cs 0000: req=%b err=%b rd_data=%h", slot_req, err, rd_data);

    // Reset in WAIT_WR cycle 2.
    mon_en    = 1'b0;
    cs        = 4'b0100;
    wr_data   = 16'h1111;
    wr_strobe = 1'b1;
    @(negedge clk);
    wr_strobe = 1'b0;
    chk("mid_req",    32'(slot_req),   32'b0100);
    chk("mid_busy",   32'(busy),       32'd1);
    chk("mid_we",     32'(slot_we),    32'd1);
    chk("mid_wdata",  32'(slot_wdata), 32'h1111);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("arst_req",   32'(slot_req),   32'd0);
    chk("arst_busy",  32'(busy),       32'd0);
    chk("arst_err",   32'(err),        32'd0);
    chk("arst_rd",    32'(rd_data),    32'd0);
    chk("arst_we",    32'(slot_we),    32'd0);
    $display("reset mid-op: req=%b busy=%b err=%b", slot_req, busy, err);
    @(negedge clk);
    reset_n = 1'b1;
    mon_en  = 1'b1;
    run_vec(mkv(1, 0, 4'b0100, 16'h7E57, 16'h0000, 2, 4'b0000, 0, 1, 2, 16'h0000, 3'b000));

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
